operand_entry: RTL and testbench
================================

# operand_entry

Input-side front end for the four-bit adder datapath. It samples the board's active-low slide switches and one active-low pushbutton, then synchronizes and debounces the button. Successive button presses latch operand A, then operand B, into registers. Once both are held, it asserts a valid flag to the adder, whose 5-bit result returns to the LEDs through the negative-logic display driver.

## Interface
Parameters:
- DEBOUNCE_CNT, 250000, consecutive stable cycles required before a button level change is accepted (5 ms at 50 MHz); legal range 2 to 2^20.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CNT.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SwIn  input  4  raw slide switches, active-low (0 = switch on = logic 1).
- BtnIn  input  1  raw pushbutton, active-low (0 = pressed).
- OpA  output  4  latched operand A, positive logic.
- OpB  output  4  latched operand B, positive logic.
- OpValid  output  1  high while both operands are latched.
- Phase  output  2  current FSM state code, for status LEDs.

## Operation
- Synchronizer:
  - SwIn and BtnIn each pass through two flip-flops.
  - The switch value used for capture is the bitwise inverse of the second sync stage.
- Debounce (button only):
  - BtnStable register resets to 1 (released).
  - Each cycle the synced button differs from BtnStable, the counter increments. When they are equal, the counter clears to 0.
  - When the counter equals DEBOUNCE_CNT-1 and the levels still differ, BtnStable takes the synced level and the counter clears, both on the same edge.
  - Any bounce before that point restarts the count.
- Press pulse:
  - Asserted for exactly one cycle, registered on the same edge where BtnStable goes 1 to 0.
  - A release (0 to 1) produces no pulse.
- FSM states (Phase code):
  - WAIT_A = 00
  - WAIT_B = 01
  - DONE = 10
  - Code 11 is unused; if it is ever reached, the FSM returns to WAIT_A on the next edge.
- Transitions, all on a press pulse:
  - WAIT_A: OpA takes the inverted synced switches; go to WAIT_B.
  - WAIT_B: OpB takes the inverted synced switches; go to DONE; OpValid rises.
  - DONE: OpA, OpB and OpValid clear to 0; go to WAIT_A.
  - With no press pulse, all registers hold.
- OpValid is a registered output, high exactly while the FSM is in DONE.
- Switches are not debounced. They must be static before the press is accepted, and they are sampled only on the press cycle.

## Timing
- Reset values:
  - OpA = 0, OpB = 0, OpValid = 0, Phase = 00.
  - Sync flip-flops = 1 (released / off).
  - BtnStable = 1; counter = 0.
- Reset asserted mid-count or mid-sequence discards all progress immediately, asynchronously. The first edge after deassertion behaves as a fresh start.
- Latency from a BtnIn falling edge (held low without bounce) to the press pulse: 2 sync cycles plus DEBOUNCE_CNT cycles.
- OpA, OpB, Phase and OpValid update on the edge after the press pulse, i.e. one cycle later.
- Switch value captured is the second-stage sync value in the press-pulse cycle. SwIn must be stable at least 2 cycles before that cycle.
- Holding the button indefinitely yields one pulse only. A new pulse requires a debounced release followed by a debounced press.
- A release glitch shorter than DEBOUNCE_CNT cycles while held produces no extra pulse.
- The counter never exceeds DEBOUNCE_CNT-1, so there is no wrap-around.

## Structure
- Shared package/include operand_entry_defs:
  - Phase state codes WAIT_A, WAIT_B, DONE.
  - Default DEBOUNCE_CNT value.
- Sub-module btn_debounce:
  - Contains the 2-flop sync, counter, BtnStable and the press-pulse logic.
  - Ports: Clk, Reset, BtnIn, Press.
  - Parameters: DEBOUNCE_CNT, CNT_W.
- The top level holds the switch synchronizer, the FSM and the operand registers.

## Test plan
All scenarios use DEBOUNCE_CNT = 4.
- Reset check: after Reset, with BtnIn = 1 and SwIn = 1111 → OpA = 0, OpB = 0, OpValid = 0, Phase = 00 for 20 cycles.
- Full sequence:
  - SwIn = 1010 (value 0101), then press → OpA = 0101, Phase = 01, exactly 7 cycles after the BtnIn fall.
  - Release, SwIn = 0110 (value 1001), press → OpB = 1001, OpValid = 1, Phase = 10.
- Bounce rejection: BtnIn toggles low/high every 2 cycles for 20 cycles, then is held high → no press pulse; Phase unchanged.
- Hold: BtnIn low for 100 cycles → exactly one press pulse and one state advance.
- Clear from DONE: with OpValid = 1, press → on the following edge OpA = 0, OpB = 0, OpValid = 0, Phase = 00.
- Mid-count reset: BtnIn low for 3 cycles, Reset pulsed, BtnIn held low → pulse occurs 2 + 4 cycles after the Reset deassertion edge; Phase ends at 01.

Source files
------------

// File: rtl/operand_entry_defs.sv
// Shared definitions for the operand entry front end: FSM phase codes and
// default debounce sizing.
package operand_entry_defs;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        DONE   = 2'b10
    } phase_t;

    // 5 ms at 50 MHz; the counter width must cover DEBOUNCE_CNT-1
    localparam int DEBOUNCE_CNT_DEF = 250000;
    localparam int CNT_W_DEF        = 20;

endpackage

// File: rtl/btn_debounce.sv
// Active-low pushbutton conditioner: two-flop synchronizer, debounce counter
// and a one-cycle pulse on each accepted press (released -> pressed).
module btn_debounce
    import operand_entry_defs::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnIn,
    output logic Press
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= BtnIn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any cycle where the level matches the stable value restarts the count
            if (r_sync2 != r_stable) begin
                if (r_cnt == LP_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    r_press  <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign Press = r_press;

endmodule

// File: rtl/operand_entry.sv
// Switch/button front end for the 4-bit adder: successive debounced presses
// latch operand A, then operand B, then clear both.
module operand_entry
    import operand_entry_defs::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] SwIn,
    input  logic       BtnIn,
    output logic [3:0] OpA,
    output logic [3:0] OpB,
    output logic       OpValid,
    output logic [1:0] Phase
);

    logic [3:0] r_sw1;
    logic [3:0] r_sw2;
    phase_t     r_phase;
    logic [3:0] r_opa;
    logic [3:0] r_opb;
    logic       r_valid;

    logic       w_press;
    logic [3:0] w_sw;
    phase_t     w_phase_next;
    logic [3:0] w_opa_next;
    logic [3:0] w_opb_next;
    logic       w_valid_next;

    btn_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .Clk   (Clk),
        .Reset (Reset),
        .BtnIn (BtnIn),
        .Press (w_press)
    );

    // Switches are active-low; undebounced, sampled only on a press cycle
    assign w_sw = ~r_sw2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sw1   <= 4'hF;
            r_sw2   <= 4'hF;
            r_phase <= WAIT_A;
            r_opa   <= 4'h0;
            r_opb   <= 4'h0;
            r_valid <= 1'b0;
        end else begin
            r_sw1   <= SwIn;
            r_sw2   <= r_sw1;
            r_phase <= w_phase_next;
            r_opa   <= w_opa_next;
            r_opb   <= w_opb_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        w_opa_next   = r_opa;
        w_opb_next   = r_opb;
        w_valid_next = r_valid;
        case (r_phase)
            WAIT_A: begin
                if (w_press) begin
                    w_opa_next   = w_sw;
                    w_phase_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (w_press) begin
                    w_opb_next   = w_sw;
                    w_valid_next = 1'b1;
                    w_phase_next = DONE;
                end
            end
            DONE: begin
                if (w_press) begin
                    w_opa_next   = 4'h0;
                    w_opb_next   = 4'h0;
                    w_valid_next = 1'b0;
                    w_phase_next = WAIT_A;
                end
            end
            default: begin
                // Unused code 11 recovers unconditionally
                w_valid_next = 1'b0;
                w_phase_next = WAIT_A;
            end
        endcase
    end

    assign OpA     = r_opa;
    assign OpB     = r_opb;
    assign OpValid = r_valid;
    assign Phase   = r_phase;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry with DEBOUNCE_CNT = 4: directed
// scenarios, a vector table of press sequences and randomized button activity.
module tb_operand_entry;

    localparam int DB = 4;

    logic       Clk;
    logic       Reset;
    logic [3:0] SwIn;
    logic       BtnIn;
    logic [3:0] OpA;
    logic [3:0] OpB;
    logic       OpValid;
    logic [1:0] Phase;

    int checks = 0;
    int errors = 0;

    operand_entry #(
        .DEBOUNCE_CNT (DB),
        .CNT_W        (3)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .SwIn    (SwIn),
        .BtnIn   (BtnIn),
        .OpA     (OpA),
        .OpB     (OpB),
        .OpValid (OpValid),
        .Phase   (Phase)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural reference: the button level is accepted once the synced
    // level has differed from the accepted level for DB consecutive samples.
    logic       m_b1, m_b2, m_bs, m_press, m_valid;
    logic [3:0] m_s1, m_s2, m_opa, m_opb;
    int         m_phase;
    logic       hist[$];

    task automatic model_reset();
        m_b1 = 1'b1; m_b2 = 1'b1; m_bs = 1'b1; m_press = 1'b0;
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_opa = 4'h0; m_opb = 4'h0; m_valid = 1'b0; m_phase = 0;
        hist.delete();
    endtask

    task automatic model_step(input logic btn, input logic [3:0] sw);
        bit all_diff;
        if (m_press) begin
            if (m_phase == 0) begin
                m_opa = ~m_s2; m_phase = 1;
            end else if (m_phase == 1) begin
                m_opb = ~m_s2; m_valid = 1'b1; m_phase = 2;
            end else begin
                m_opa = 4'h0; m_opb = 4'h0; m_valid = 1'b0; m_phase = 0;
            end
        end
        hist.push_back(m_b2);
        if (hist.size() > DB) void'(hist.pop_front());
        m_press  = 1'b0;
        all_diff = (hist.size() == DB);
        foreach (hist[k]) if (hist[k] == m_bs) all_diff = 0;
        if (all_diff) begin
            m_press = m_bs;
            m_bs    = ~m_bs;
            hist.delete();
        end
        m_s2 = m_s1; m_s1 = sw;
        m_b2 = m_b1; m_b1 = btn;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step(BtnIn, SwIn);
        @(negedge Clk);
        check("model", {21'd0, OpA, OpB, OpValid, Phase},
              {21'd0, m_opa, m_opb, m_valid, m_phase[1:0]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges; the next rising edge is the first fresh one
    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        #1;
        check("async_clear", {21'd0, OpA, OpB, OpValid, Phase}, 32'd0);
        #2;
        Reset = 1'b0;
    endtask

    task automatic wait_phase(input logic [1:0] target, output int n);
        n = 0;
        while (Phase != target && n < 50) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic [3:0] sw;
        logic [3:0] opa;
        logic [3:0] opb;
        logic       valid;
        logic [1:0] phase;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        int changes;
        logic [1:0] prev;

        tbl[0] = '{4'b1010, 4'h5, 4'h0, 1'b0, 2'b01};
        tbl[1] = '{4'b0110, 4'h5, 4'h9, 1'b1, 2'b10};
        tbl[2] = '{4'b0000, 4'h0, 4'h0, 1'b0, 2'b00};
        tbl[3] = '{4'b0011, 4'hC, 4'h0, 1'b0, 2'b01};
        tbl[4] = '{4'b1111, 4'hC, 4'h0, 1'b1, 2'b10};
        tbl[5] = '{4'b1110, 4'h0, 4'h0, 1'b0, 2'b00};

        Reset = 1'b1; BtnIn = 1'b1; SwIn = 4'hF;
        model_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_idle", {21'd0, OpA, OpB, OpValid, Phase}, 32'd0);
        end

        // First press: latency from BtnIn fall to OpA update
        SwIn = 4'b1010;
        ticks(3);
        BtnIn = 1'b0;
        wait_phase(2'b01, n);
        check("press_latency", n, 7);
        check("opa_first", {28'd0, OpA}, 32'h5);
        $display("press A: OpA=%h Phase=%b after %0d cycles", OpA, Phase, n);
        BtnIn = 1'b1;
        ticks(10);

        SwIn = 4'b0110;
        ticks(3);
        BtnIn = 1'b0;
        ticks(10);
        check("opb_second", {27'd0, OpB, OpValid}, {27'd0, 4'h9, 1'b1});
        check("phase_done", {30'd0, Phase}, 32'd2);
        $display("press B: OpB=%h OpValid=%b Phase=%b", OpB, OpValid, Phase);
        BtnIn = 1'b1;
        ticks(10);

        // Clear from DONE
        BtnIn = 1'b0;
        wait_phase(2'b00, n);
        check("clear_bound", {31'd0, n < 50}, 32'd1);
        check("clear_state", {21'd0, OpA, OpB, OpValid, Phase}, 32'd0);
        $display("clear: Phase=%b OpValid=%b", Phase, OpValid);
        BtnIn = 1'b1;
        ticks(10);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 20; i++) begin
            BtnIn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        BtnIn = 1'b1;
        ticks(10);
        check("bounce_phase", {30'd0, Phase}, 32'd0);
        $display("bounce: Phase=%b", Phase);

        // Long hold: exactly one advance
        changes = 0;
        BtnIn = 1'b0;
        for (int i = 0; i < 100; i++) begin
            prev = Phase;
            tick();
            if (Phase != prev) changes++;
        end
        check("hold_changes", changes, 1);
        check("hold_phase", {30'd0, Phase}, 32'd1);
        $display("hold: %0d state change(s)", changes);
        BtnIn = 1'b1;
        ticks(10);

        // Table of press sequences from a fresh start
        do_reset();
        for (int r = 0; r < 6; r++) begin
            SwIn = tbl[r].sw;
            ticks(3);
            BtnIn = 1'b0;
            ticks(8);
            BtnIn = 1'b1;
            ticks(8);
            check("table", {21'd0, OpA, OpB, OpValid, Phase},
                  {21'd0, tbl[r].opa, tbl[r].opb, tbl[r].valid, tbl[r].phase});
            $display("row %0d: SwIn=%b OpA=%h OpB=%h OpValid=%b Phase=%b",
                     r, tbl[r].sw, OpA, OpB, OpValid, Phase);
        end

        // Mid-count reset while in WAIT_B
        SwIn = 4'b0101;
        ticks(3);
        BtnIn = 1'b0;
        ticks(8);
        BtnIn = 1'b1;
        ticks(8);
        BtnIn = 1'b0;
        ticks(3);
        do_reset();
        wait_phase(2'b01, n);
        check("midreset_latency", n, 7);
        $display("mid-count reset: advance %0d cycles after deassertion", n);
        BtnIn = 1'b1;
        ticks(10);

        // Randomized button runs and switch changes
        for (int r = 0; r < 3000; r++) begin
            int len;
            BtnIn = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) SwIn = 4'($urandom);
                tick();
            end
        end
        $display("random: final OpA=%h OpB=%h OpValid=%b Phase=%b", OpA, OpB, OpValid, Phase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
